// File: rtl/axi4_if.sv
// axi4_if: AXI4 read address and read data channel bundle.
interface axi4_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 4
);
  logic [ID_WIDTH-1:0]      arid;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [7:0]               arlen;
  logic [2:0]               arsize;
  logic [1:0]               arburst;
  logic                     arvalid;
  logic                     arready;
  logic [ID_WIDTH-1:0]      rid;
  logic [DATA_WIDTH-1:0]    rdata;
  logic [1:0]               rresp;
  logic                     rlast;
  logic [3:0]               ruser;
  logic                     rvalid;
  logic                     rready;
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, ruser, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, ruser, rvalid
  );
endinterface

// File: rtl/axi4_slave_read_responder.sv
// axi4_slave_read_responder: single-outstanding AXI4 read slave returning beat address as data.
module axi4_slave_read_responder #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 4,
  parameter int READ_LATENCY  = 2
) (
  input logic   aclk,
  input logic   areset,
  axi4_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;
  localparam int MAXS = $clog2(DATA_WIDTH / 8);
  state_t state_q, state_d;
  logic live_q;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] beat_q, beat_d, len_q, len_d;
  logic [2:0] size_q, size_d;
  logic [1:0] burst_q, burst_d;
  logic err_q, err_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d, lo_q, lo_d, hi_q, hi_d;
  logic [ADDRESS_WIDTH-1:0] ar_b, ar_l, ar_lo, b, inc, nxt;
  logic ar_err, ar_hs, r_hs, last;
  assign ar_b   = ADDRESS_WIDTH'(1) << bus.arsize;
  assign ar_l   = ADDRESS_WIDTH'({1'b0, bus.arlen} + 9'd1) << bus.arsize;
  assign ar_lo  = bus.araddr & ~(ar_l - 1'b1);
  assign ar_err = bus.arburst == 2'b11 || bus.arsize > 3'(MAXS) ||
                  (bus.arburst == 2'b10 && (!(bus.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                  (bus.araddr & (ar_b - 1'b1)) != '0));
  assign b    = ADDRESS_WIDTH'(1) << size_q;
  assign inc  = (addr_q & ~(b - 1'b1)) + b;
  // WRAP bursts are known aligned when OKAY, so the aligned increment equals addr+B
  assign nxt  = burst_q == 2'b00 ? addr_q : (burst_q == 2'b10 && inc == hi_q) ? lo_q : inc;
  assign last = beat_q == len_q;
  assign bus.arready = state_q == IDLE && live_q;
  assign bus.rvalid  = state_q == DATA;
  assign ar_hs = bus.arvalid && bus.arready;
  assign r_hs  = bus.rvalid && bus.rready;
  assign bus.rid   = id_q;
  assign bus.rdata = bus.rvalid && !err_q ? DATA_WIDTH'(addr_q) : '0;
  assign bus.rresp = bus.rvalid && err_q ? 2'b10 : 2'b00;
  assign bus.rlast = bus.rvalid && last;
  assign bus.ruser = '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = err_q;
    id_d    = id_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    if (ar_hs) begin
      state_d = WAIT;
      cnt_d   = 4'(READ_LATENCY);
      beat_d  = '0;
      len_d   = bus.arlen;
      size_d  = bus.arsize;
      burst_d = bus.arburst;
      err_d   = ar_err;
      id_d    = bus.arid;
      addr_d  = bus.araddr;
      lo_d    = ar_lo;
      hi_d    = ar_lo + ar_l;
    end else if (state_q == WAIT) begin
      state_d = cnt_q == '0 ? DATA : WAIT;
      cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 4'd1;
    end else if (r_hs) begin
      state_d = last ? IDLE : DATA;
      beat_d  = last ? beat_q : beat_q + 8'd1;
      addr_d  = last ? addr_q : nxt;
    end
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      cnt_q   <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end
endmodule

// File: tb/tb_axi4_slave_read_responder.sv
// tb_axi4_slave_read_responder: table vectors, corner sequences and random bursts vs a reference model.
module tb_axi4_slave_read_responder;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  axi4_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();
  axi4_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus0 ();
  axi4_slave_read_responder #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .READ_LATENCY(LAT))
    dut (.aclk(clk), .areset(rst), .bus(bus));
  axi4_slave_read_responder #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .READ_LATENCY(0))
    dut0 (.aclk(clk), .areset(rst), .bus(bus0));

  typedef struct {
    logic [3:0]       id;
    logic [31:0]      a;
    int               len, size, burst, mode;
    logic [3:0][31:0] d;
    logic [1:0]       resp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic mdl_err(logic [31:0] a, int len, int size, int burst);
    longint bb = longint'(1) << size;
    return burst == 3 || bb > 4 || (burst == 2 && !(len inside {1, 3, 7, 15})) ||
           (burst == 2 && (longint'(a) % bb) != 0);
  endfunction

  function automatic logic [31:0] mdl_addr(logic [31:0] a, int len, int size, int burst, int n);
    longint bb = longint'(1) << size;
    longint ll = longint'(len + 1) * bb;
    longint aa = longint'(a);
    longint base = (aa / ll) * ll;
    if (burst == 0) return a;
    if (burst == 2) return 32'(base + ((aa - base) + n * bb) % ll);
    return n == 0 ? a : 32'((aa / bb) * bb + n * bb);
  endfunction

  // mode 0: rready always 1, 1: toggling starting low at first rvalid, 2: random
  task automatic run_txn(input logic [3:0] id, input logic [31:0] a, input int len, input int size,
                         input int burst, input int mode, output logic [3:0][31:0] d, output logic [1:0] resp);
    int c, n, first_c, last_c;
    logic err;
    logic [63:0] exp, got;
    d = '0;
    resp = 2'b00;
    err = mdl_err(a, len, size, burst);
    bus.arid = id; bus.araddr = a; bus.arlen = 8'(len); bus.arsize = 3'(size);
    bus.arburst = 2'(burst); bus.arvalid = 1'b1; bus.rready = 1'b0;
    c = 0;
    while (!bus.arready && c < 20) begin step(); c++; end
    check("ar_accept", 64'(bus.arready), 64'd1);
    if (!bus.arready) begin bus.arvalid = 1'b0; return; end
    step();
    bus.arvalid = 1'b0;
    c = 0; n = 0; first_c = -1; last_c = -1;
    while (n <= len && c < 700) begin
      if (bus.rvalid && first_c < 0) first_c = c;
      bus.rready = mode == 0 ? 1'b1 : mode == 1 ? (first_c >= 0 && ((c - first_c) % 2 == 1)) :
                   ($urandom_range(0, 9) < 7);
      if (bus.rvalid) begin
        exp = {21'd0, id, err ? 32'd0 : mdl_addr(a, len, size, burst, n), err ? 2'b10 : 2'b00,
               n == len, 4'h0};
        got = {21'd0, bus.rid, bus.rdata, bus.rresp, bus.rlast, bus.ruser};
        check("beat", got, exp);
        if (bus.rready) begin
          if (n < 4) d[n] = bus.rdata;
          resp = bus.rresp;
          if (n == len) last_c = c;
          n++;
        end
      end
      step();
      c++;
    end
    bus.rready = 1'b0;
    check("first_rvalid_latency", 64'(first_c), 64'(LAT + 1));
    check("beat_count", 64'(n), 64'(len + 1));
    check("post_last_idle", {62'd0, bus.rvalid, bus.arready}, 64'b01);
    if (mode == 1) check("toggle_span", 64'(last_c - first_c + 1), 64'(2 * (len + 1)));
  endtask

  initial begin
    vec_t v[8];
    logic [3:0][31:0] d;
    logic [1:0] resp;
    int c, hs, hc[2];
    v[0] = '{4'd5, 32'h1002, 3, 2, 1, 0, {32'h100C, 32'h1008, 32'h1004, 32'h1002}, 2'b00};
    v[1] = '{4'd1, 32'h0038, 3, 2, 2, 0, {32'h0034, 32'h0030, 32'h003C, 32'h0038}, 2'b00};
    v[2] = '{4'd2, 32'h0200, 2, 2, 0, 1, {32'h0, 32'h0200, 32'h0200, 32'h0200}, 2'b00};
    v[3] = '{4'd3, 32'h0100, 1, 2, 3, 0, {32'h0, 32'h0, 32'h0, 32'h0}, 2'b10};
    v[4] = '{4'd4, 32'h0040, 2, 2, 2, 0, {32'h0, 32'h0, 32'h0, 32'h0}, 2'b10};
    v[5] = '{4'd6, 32'h0100, 1, 3, 1, 0, {32'h0, 32'h0, 32'h0, 32'h0}, 2'b10};
    v[6] = '{4'd7, 32'h003A, 3, 2, 2, 0, {32'h0, 32'h0, 32'h0, 32'h0}, 2'b10};
    v[7] = '{4'd9, 32'h00FF, 3, 0, 1, 2, {32'h0102, 32'h0101, 32'h0100, 32'h00FF}, 2'b00};
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus0.arid = '0; bus0.araddr = '0; bus0.arlen = '0; bus0.arsize = 3'd2; bus0.arburst = 2'b01;
    bus0.arvalid = 1'b0; bus0.rready = 1'b0;
    #22;
    check("reset_outputs", {21'd0, bus.arready, bus.rvalid, bus.rlast, bus.rid, bus.rdata, bus.rresp, bus.ruser},
          64'd0);
    rst = 1'b0;
    #1;
    check("arready_before_edge", 64'(bus.arready), 64'd0);
    step();
    check("arready_after_edge", 64'(bus.arready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      run_txn(v[i].id, v[i].a, v[i].len, v[i].size, v[i].burst, v[i].mode, d, resp);
      for (int k = 0; k < 4 && k <= v[i].len; k++) check($sformatf("vec%0d_d%0d", i, k), 64'(d[k]), 64'(v[i].d[k]));
      check($sformatf("vec%0d_resp", i), 64'(resp), 64'(v[i].resp));
    end

    // reset in the middle of an 8-beat INCR
    bus.arid = 4'd3; bus.araddr = 32'h4000; bus.arlen = 8'd7; bus.arsize = 3'd2; bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    c = 0;
    while (!bus.arready && c < 20) begin step(); c++; end
    step();
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    c = 0;
    while (!bus.rvalid && c < 20) begin step(); c++; end
    check("midburst_rvalid_seen", 64'(bus.rvalid), 64'd1);
    step();
    step();
    #3 rst = 1'b1;
    #1;
    check("async_reset_outputs", {62'd0, bus.rvalid, bus.arready}, 64'd0);
    step();
    step();
    #2 rst = 1'b0;
    #1;
    check("arready_held_after_release", 64'(bus.arready), 64'd0);
    step();
    check("after_reset_idle", {62'd0, bus.arready, bus.rvalid}, 64'b10);
    bus.rready = 1'b0;
    run_txn(v[0].id, v[0].a, v[0].len, v[0].size, v[0].burst, 0, d, resp);
    check("post_reset_d0", 64'(d[0]), 64'h1002);

    // back-to-back AR on the zero-latency instance
    bus0.araddr = 32'h10; bus0.arlen = 8'd0; bus0.arvalid = 1'b1; bus0.rready = 1'b1;
    c = 0; hs = 0;
    while (hs < 2 && c < 30) begin
      if (bus0.rvalid) check("no_ar_during_data", 64'(bus0.arready), 64'd0);
      if (bus0.arvalid && bus0.arready) begin hc[hs] = c; hs++; end
      step();
      c++;
    end
    bus0.arvalid = 1'b0;
    check("b2b_accepts", 64'(hs), 64'd2);
    if (hs == 2) check("b2b_spacing", 64'(hc[1] - hc[0]), 64'd3);
    repeat (4) step();

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int len, size, burst;
      a = $urandom;
      burst = $urandom_range(0, 3);
      size = $urandom_range(0, 3);
      len = $urandom_range(0, 9) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 15);
      if (burst == 2 && $urandom_range(0, 1) == 1) begin
        len = (2 << $urandom_range(0, 3)) - 1;
        a = a & ~((32'd1 << size) - 32'd1);
      end
      run_txn(4'($urandom), a, len, size, burst, 2, d, resp);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
